// File: rtl/snn_noc_pkg.sv
// Shared NoC definitions for the SNN endpoints: packet field layout,
// operation codes and the PE frame-loader state encoding.
package snn_noc_pkg;

  localparam int unsigned PACKET_W = 39;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned FILTER_W = 24;
  localparam int unsigned SPIKE_W  = 5;

  localparam int unsigned DST_LSB    = 0;
  localparam int unsigned SRC_LSB    = 4;
  localparam int unsigned OP_LSB     = 8;
  localparam int unsigned FILTER_LSB = 10;
  localparam int unsigned SPIKE_LSB  = 34;

  typedef enum logic [1:0] {
    OP_FULL   = 2'd0,
    OP_SPIKE  = 2'd1,
    OP_FILTER = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BUSY    = 2'd2
  } loader_state_e;

endpackage

// File: rtl/snn_pkt_unpack.sv
// Combinational slicing of a NoC packet into its fields; shared by the
// NoC endpoints so the field layout lives in one place.
module snn_pkt_unpack
  import snn_noc_pkg::*;
#(
  parameter int unsigned PACKET_WIDTH       = PACKET_W,
  parameter int unsigned ADDR_WIDTH         = ADDR_W,
  parameter int unsigned OP_WIDTH           = OP_W,
  parameter int unsigned FILTER_FRAME_WIDTH = FILTER_W,
  parameter int unsigned SPIKE_FRAME_WIDTH  = SPIKE_W
) (
  input  logic [PACKET_WIDTH-1:0]       pkt_data,
  output logic [ADDR_WIDTH-1:0]         dst,
  output logic [ADDR_WIDTH-1:0]         src,
  output logic [OP_WIDTH-1:0]           op,
  output logic [FILTER_FRAME_WIDTH-1:0] filter,
  output logic [SPIKE_FRAME_WIDTH-1:0]  spike
);

  always_comb begin
    dst    = pkt_data[DST_LSB    +: ADDR_WIDTH];
    src    = pkt_data[SRC_LSB    +: ADDR_WIDTH];
    op     = pkt_data[OP_LSB     +: OP_WIDTH];
    filter = pkt_data[FILTER_LSB +: FILTER_FRAME_WIDTH];
    spike  = pkt_data[SPIKE_LSB  +: SPIKE_FRAME_WIDTH];
  end

endmodule

// File: rtl/pe_frame_loader.sv
// PE-side loader: collects filter/spike frames from NoC packets, then runs
// a start/ack/done handshake with the PE datapath while holding frames stable.
module pe_frame_loader
  import snn_noc_pkg::*;
#(
  parameter int unsigned           PACKET_WIDTH       = PACKET_W,
  parameter int unsigned           ADDR_WIDTH         = ADDR_W,
  parameter int unsigned           OP_WIDTH           = OP_W,
  parameter int unsigned           FILTER_FRAME_WIDTH = FILTER_W,
  parameter int unsigned           SPIKE_FRAME_WIDTH  = SPIKE_W,
  parameter logic [ADDR_WIDTH-1:0] PE_ADDR            = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic [PACKET_WIDTH-1:0]       pkt_data,
  output logic [FILTER_FRAME_WIDTH-1:0] filter_frame,
  output logic [SPIKE_FRAME_WIDTH-1:0]  spike_frame,
  output logic [ADDR_WIDTH-1:0]         filter_src,
  output logic                          pe_start,
  input  logic                          pe_ack,
  input  logic                          pe_done,
  output logic [7:0]                    drop_count
);

  logic [ADDR_WIDTH-1:0]         f_dst;
  logic [ADDR_WIDTH-1:0]         f_src;
  logic [OP_WIDTH-1:0]           f_op_raw;
  logic [FILTER_FRAME_WIDTH-1:0] f_filter;
  logic [SPIKE_FRAME_WIDTH-1:0]  f_spike;
  op_e                           f_op;

  loader_state_e state;
  loader_state_e next_state;
  logic          filter_loaded;
  logic          spike_loaded;

  logic xfer;
  logic drop;
  logic accept;
  logic take_filter;
  logic take_spike;
  logic filter_next;
  logic spike_next;

  snn_pkt_unpack #(
    .PACKET_WIDTH       (PACKET_WIDTH),
    .ADDR_WIDTH         (ADDR_WIDTH),
    .OP_WIDTH           (OP_WIDTH),
    .FILTER_FRAME_WIDTH (FILTER_FRAME_WIDTH),
    .SPIKE_FRAME_WIDTH  (SPIKE_FRAME_WIDTH)
  ) u_unpack (
    .pkt_data (pkt_data),
    .dst      (f_dst),
    .src      (f_src),
    .op       (f_op_raw),
    .filter   (f_filter),
    .spike    (f_spike)
  );

  assign f_op = op_e'(f_op_raw);

  // pkt_ready is only ever high in COLLECT, so xfer implies COLLECT.
  always_comb begin
    xfer        = pkt_valid && pkt_ready;
    drop        = xfer && ((f_dst != PE_ADDR) || (f_op == OP_RSVD));
    accept      = xfer && !drop;
    take_filter = accept && ((f_op == OP_FULL) || (f_op == OP_FILTER));
    take_spike  = accept && ((f_op == OP_FULL) || (f_op == OP_SPIKE));
    filter_next = filter_loaded || take_filter;
    spike_next  = spike_loaded || take_spike;

    next_state = state;
    unique case (state)
      ST_COLLECT: if (accept && filter_next && spike_next) next_state = ST_ISSUE;
      ST_ISSUE:   if (pe_ack)  next_state = ST_BUSY;
      ST_BUSY:    if (pe_done) next_state = ST_COLLECT;
      default:    next_state = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_COLLECT;
      pkt_ready     <= 1'b0;
      pe_start      <= 1'b0;
      filter_frame  <= '0;
      spike_frame   <= '0;
      filter_src    <= '0;
      filter_loaded <= 1'b0;
      spike_loaded  <= 1'b0;
      drop_count    <= '0;
    end else begin
      state     <= next_state;
      pkt_ready <= (next_state == ST_COLLECT);
      pe_start  <= (next_state == ST_ISSUE);

      if (take_filter) begin
        filter_frame  <= f_filter;
        filter_src    <= f_src;
        filter_loaded <= 1'b1;
      end

      if (take_spike) begin
        spike_frame  <= f_spike;
        spike_loaded <= 1'b1;
      end else if ((state == ST_ISSUE) && pe_ack) begin
        spike_loaded <= 1'b0;
      end

      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pe_frame_loader.sv
// Directed plus randomized bench for pe_frame_loader against a frame/flag
// reference model kept in plain variables.
module tb_pe_frame_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [38:0] pkt_data;
  logic [23:0] filter_frame;
  logic [4:0]  spike_frame;
  logic [3:0]  filter_src;
  logic        pe_start;
  logic        pe_ack;
  logic        pe_done;
  logic [7:0]  drop_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [23:0] m_filter;
  logic [4:0]  m_spike;
  logic [3:0]  m_src;
  bit          m_fok;
  bit          m_sok;
  int unsigned m_drops;

  always #5 clk = ~clk;

  pe_frame_loader #(
    .PE_ADDR (4'd0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_data     (pkt_data),
    .filter_frame (filter_frame),
    .spike_frame  (spike_frame),
    .filter_src   (filter_src),
    .pe_start     (pe_start),
    .pe_ack       (pe_ack),
    .pe_done      (pe_done),
    .drop_count   (drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_filter = '0; m_spike = '0; m_src = '0;
    m_fok = 0; m_sok = 0; m_drops = 0;
  endtask

  task automatic chk_frames(input string tag);
    chk({tag, ".filter"}, 32'(filter_frame), 32'(m_filter));
    chk({tag, ".spike"},  32'(spike_frame),  32'(m_spike));
    chk({tag, ".src"},    32'(filter_src),   32'(m_src));
    chk({tag, ".drops"},  32'(drop_count),   m_drops);
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (!pkt_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(pkt_ready), 32'd1);
  endtask

  // Offers one packet, then checks the cycle after the transfer edge.
  task automatic send(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                      input logic [23:0] flt, input logic [4:0] spk, output bit start_exp);
    wait_ready();
    pkt_valid = 1'b1;
    pkt_data  = {spk, flt, op, src, dst};
    tick();
    pkt_valid = 1'b0;
    pkt_data  = 39'($urandom);
    if (dst != 4'd0 || op == 2'd3) begin
      if (m_drops < 255) m_drops++;
      start_exp = 0;
    end else begin
      if (op != 2'd1) begin m_filter = flt; m_src = src; m_fok = 1; end
      if (op != 2'd2) begin m_spike = spk; m_sok = 1; end
      start_exp = m_fok && m_sok;
    end
    chk("send.pe_start",  32'(pe_start),  32'(start_exp));
    chk("send.pkt_ready", 32'(pkt_ready), 32'(!start_exp));
    chk_frames("send");
  endtask

  // Entered in the first pe_start cycle; finishes one cycle after pe_done.
  task automatic complete_run(input int unsigned ack_delay, input int unsigned done_delay);
    for (int unsigned i = 0; i < ack_delay; i++) begin
      chk("issue.pe_start",  32'(pe_start),  32'd1);
      chk("issue.pkt_ready", 32'(pkt_ready), 32'd0);
      tick();
    end
    pe_ack = 1'b1;
    tick();
    pe_ack = 1'b0;
    m_sok  = 0;
    chk("ack.pe_start", 32'(pe_start), 32'd0);
    for (int unsigned i = 0; i < done_delay; i++) begin
      chk("busy.pkt_ready", 32'(pkt_ready), 32'd0);
      chk("busy.pe_start",  32'(pe_start),  32'd0);
      chk_frames("busy");
      tick();
    end
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    chk("done.pkt_ready", 32'(pkt_ready), 32'd1);
    chk("done.pe_start",  32'(pe_start),  32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pkt_ready"}, 32'(pkt_ready),    32'd0);
    chk({tag, ".pe_start"},  32'(pe_start),     32'd0);
    chk({tag, ".filter"},    32'(filter_frame), 32'd0);
    chk({tag, ".spike"},     32'(spike_frame),  32'd0);
    chk({tag, ".src"},       32'(filter_src),   32'd0);
    chk({tag, ".drops"},     32'(drop_count),   32'd0);
  endtask

  initial begin
    bit          st;
    logic [1:0]  r_op;
    logic [3:0]  r_dst;

    reset = 1'b1; pkt_valid = 1'b0; pkt_data = '0; pe_ack = 1'b0; pe_done = 1'b0;
    model_reset();
    tick(); tick(); tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    chk("post_reset.ready_low", 32'(pkt_ready), 32'd0);
    tick();
    chk("post_reset.ready_high", 32'(pkt_ready), 32'd1);

    // Full packet with pe_ack already high: pe_start lasts one cycle.
    pe_ack = 1'b1;
    send(2'd0, 4'd3, 4'd0, 24'hA5C3F0, 5'b10110, st);
    chk("t1.filter", 32'(filter_frame), 32'hA5C3F0);
    chk("t1.spike",  32'(spike_frame),  32'h16);
    chk("t1.src",    32'(filter_src),   32'd3);
    tick();
    pe_ack = 1'b0;
    m_sok  = 0;
    chk("t2.pe_start_one_cycle", 32'(pe_start), 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("t2.busy_ready", 32'(pkt_ready), 32'd0);
      chk_frames("t2");
      tick();
    end
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    chk("t2.ready_after_done", 32'(pkt_ready), 32'd1);
    chk_frames("t2.after");

    // Spike-only update reuses the persistent filter.
    send(2'd1, 4'd9, 4'd0, 24'hFFFFFF, 5'b00011, st);
    chk("t3.start",  32'(pe_start),     32'd1);
    chk("t3.filter", 32'(filter_frame), 32'hA5C3F0);
    chk("t3.spike",  32'(spike_frame),  32'h03);
    complete_run(2, 3);

    // Filter reload alone does not start; the following spike does.
    send(2'd2, 4'd5, 4'd0, 24'h010203, 5'b11111, st);
    chk("t4.no_start", 32'(pe_start), 32'd0);
    tick();
    chk("t4.still_no_start", 32'(pe_start), 32'd0);
    send(2'd1, 4'd1, 4'd0, 24'h0, 5'(~$urandom_range(0, 31)), st);
    chk("t4.start",  32'(pe_start),     32'd1);
    chk("t4.filter", 32'(filter_frame), 32'h010203);
    chk("t4.src",    32'(filter_src),   32'd5);
    complete_run(0, 1);

    // Stray ack/done while collecting are ignored.
    pe_ack = 1'b1; pe_done = 1'b1;
    tick();
    pe_ack = 1'b0; pe_done = 1'b0;
    chk("stray.pe_start",  32'(pe_start),  32'd0);
    chk("stray.pkt_ready", 32'(pkt_ready), 32'd1);

    // Randomized packets against the model.
    for (int unsigned k = 0; k < 40; k++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_dst = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      send(r_op, 4'($urandom), r_dst, 24'($urandom), 5'($urandom), st);
      if (st) complete_run($urandom_range(0, 3), $urandom_range(0, 4));
    end

    // Drop flood: saturates drop_count, never starts.
    for (int unsigned k = 0; k < 300; k++) begin
      if (k[0]) send(2'd3, 4'($urandom), 4'd0, 24'($urandom), 5'($urandom), st);
      else      send(2'($urandom), 4'($urandom), 4'd7, 24'($urandom), 5'($urandom), st);
    end
    chk("drop.saturated", 32'(drop_count), 32'd255);
    chk("drop.no_start",  32'(pe_start),   32'd0);

    // Reset while BUSY clears everything, including filter_loaded.
    send(2'd1, 4'd2, 4'd0, 24'h0, 5'b01010, st);
    chk("rb.start", 32'(pe_start), 32'd1);
    pe_ack = 1'b1;
    tick();
    pe_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk_reset_vals("rb");
    tick();
    chk("rb.ready", 32'(pkt_ready), 32'd1);
    send(2'd1, 4'd4, 4'd0, 24'h0, 5'b00111, st);
    chk("rb.no_start", 32'(pe_start), 32'd0);
    tick(); tick();
    chk("rb.still_no_start", 32'(pe_start),  32'd0);
    chk("rb.ready_again",    32'(pkt_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
